periph_demux_multi: RTL and testbench
=====================================

// Module: periph_demux_multi
// PURPOSE
//  Parametrised successor of the cluster core-side peripheral demultiplexer. Routes one core
//  data port to NB_TARGETS low-latency peripheral targets (event unit, DMA, HWPE, ...) by decoding an
//  address window. Tracks up to MAX_OUTSTANDING in-order transactions in a destination FIFO.
//  Answers accesses to unmapped windows with an error response, so the core never hangs.
// PARAMETERS
//  ADDR_WIDTH       32          core address width
//  DATA_WIDTH       32          data width
//  BE_WIDTH         DATA_WIDTH/8  byte-enable width
//  NB_TARGETS       4           number of peripheral targets, 1..2**SEL_WIDTH
//  SEL_LSB          10          lowest address bit of the target-select field
//  SEL_WIDTH        4           width of the target-select field
//  REGION_MASK      32'h000F_C000  address bits compared for region hit
//  REGION_VALUE     32'h0000_4000  required value of masked bits (0x1020_4000-0x1020_7FFF window)
//  MAX_OUTSTANDING  2           destination FIFO depth, >=1
// PORTS
//  clk              in   1                     clock
//  rst_i            in   1                     synchronous reset, active-high
//  data_req_i       in   1                     core request
//  data_add_i       in   ADDR_WIDTH            core address
//  data_wen_i       in   1                     0=write, 1=read
//  data_wdata_i     in   DATA_WIDTH            write data
//  data_be_i        in   BE_WIDTH              byte enables
//  data_gnt_o       out  1                     grant to core
//  data_r_valid_o   out  1                     response valid
//  data_r_rdata_o   out  DATA_WIDTH            response read data
//  data_r_opc_o     out  1                     response error (1 = unmapped)
//  tgt_req_o        out  NB_TARGETS            per-target request
//  tgt_add_o        out  ADDR_WIDTH            broadcast address
//  tgt_wen_o / tgt_wdata_o / tgt_be_o  out     broadcast wen/wdata/be
//  tgt_gnt_i        in   NB_TARGETS            per-target grant
//  tgt_r_valid_i    in   NB_TARGETS            per-target response valid
//  tgt_r_rdata_i    in   NB_TARGETS*DATA_WIDTH per-target read data, packed, target k at [k*DATA_WIDTH +: DATA_WIDTH]
//  tgt_r_opc_i      in   NB_TARGETS            per-target response error
//  stray_resp_o     out  1                     1-cycle pulse: r_valid from a non-head target or with an empty FIFO
// BEHAVIOUR
//  - Decode:
//    - hit = (data_add_i & REGION_MASK) == REGION_VALUE.
//    - sel = data_add_i[SEL_LSB +: SEL_WIDTH].
//    - Mapped when hit && sel < NB_TARGETS; otherwise the access is UNMAPPED.
//  - Full FIFO (count == MAX_OUTSTANDING): all tgt_req_o = 0 and data_gnt_o = 0, regardless of a same-cycle pop.
//  - Not full, mapped: tgt_req_o[sel] = data_req_i; data_gnt_o = tgt_gnt_i[sel]. Combinational, zero added latency.
//  - Not full, UNMAPPED: data_gnt_o = data_req_i (internal error target); no tgt_req_o is raised.
//  - Address/wen/wdata/be are broadcast unconditionally to all targets.
//  - Push: a handshake (data_req_i && data_gnt_o) pushes the destination (sel, or UNMAPPED) at the clock edge.
//  - Response mux: driven combinationally from the FIFO head.
//    - Head = target k: data_r_valid_o/data_r_rdata_o/data_r_opc_o = tgt_r_valid_i[k] / slice k / tgt_r_opc_i[k].
//    - Head = UNMAPPED: data_r_valid_o = 1, rdata = 0, opc = 1. Earliest response is the cycle after the grant.
//    - Empty FIFO: data_r_valid_o = 0, rdata = 0, opc = 0.
//  - Pop: when data_r_valid_o = 1.
//    - A simultaneous push and pop leaves count unchanged; the pointers wrap modulo MAX_OUTSTANDING.
//  - Targets respond in order, at least 1 cycle after their grant.
//    - tgt_r_valid_i from a target other than the head, or with an empty FIFO, is dropped.
//    - Each such cycle pulses stray_resp_o.
//  - Reset, including mid-transaction: FIFO empty, pointers and count 0. All outputs are then 0 (combinational,
//    no request pending). Late target responses after reset are dropped and flagged via stray_resp_o.
//  - Targets are never granted while full, so the FIFO never overflows. Simulation asserts: no push when full,
//    no pop when empty, NB_TARGETS <= 2**SEL_WIDTH.
// TESTING
//  1. Read 0x1020_4000 (sel 0), tgt_gnt_i[0]=1 -> gnt same cycle; tgt0 r_valid next cycle rdata=0xCAFE
//     -> data_r_valid_o=1, rdata=0xCAFE, opc=0.
//  2. Write 0x1020_4C00 (sel 3, NB_TARGETS=4) -> only tgt_req_o[3] asserted; opc from tgt_r_opc_i[3] forwarded.
//  3. Read 0x1020_5000 (sel 4) and 0x1030_0000 (region miss) -> gnt same cycle, no tgt_req_o;
//     next cycle r_valid=1, rdata=0, opc=1.
//  4. MAX_OUTSTANDING=2: back-to-back grants to tgt1, tgt2 with responses withheld -> third request sees
//     gnt=0, tgt_req_o=0. tgt1 responds -> third request granted in the next cycle. Responses arrive in order.
//  5. tgt2 r_valid while head=tgt1 -> stray_resp_o=1 for 1 cycle, data_r_valid_o=0, FIFO unchanged.
//  6. rst_i=1 for 1 cycle with 2 outstanding -> count 0, outputs 0. A subsequent late tgt r_valid
//     -> stray_resp_o pulse only.

Source files
------------

// File: rtl/periph_demux_multi.sv
// periph_demux_multi: routes one core data port to NB_TARGETS peripheral targets
// by address window, tracks in-order outstanding transactions in a small
// destination FIFO, and answers unmapped accesses with an error response.
module periph_demux_multi #(
  parameter int                    ADDR_WIDTH      = 32,
  parameter int                    DATA_WIDTH      = 32,
  parameter int                    BE_WIDTH        = DATA_WIDTH / 8,
  parameter int                    NB_TARGETS      = 4,
  parameter int                    SEL_LSB         = 10,
  parameter int                    SEL_WIDTH       = 4,
  parameter logic [ADDR_WIDTH-1:0] REGION_MASK     = 32'h000F_C000,
  parameter logic [ADDR_WIDTH-1:0] REGION_VALUE    = 32'h0000_4000,
  parameter int                    MAX_OUTSTANDING = 2
) (
  input  logic                             clk,
  input  logic                             rst_i,
  input  logic                             data_req_i,
  input  logic [ADDR_WIDTH-1:0]            data_add_i,
  input  logic                             data_wen_i,
  input  logic [DATA_WIDTH-1:0]            data_wdata_i,
  input  logic [BE_WIDTH-1:0]              data_be_i,
  output logic                             data_gnt_o,
  output logic                             data_r_valid_o,
  output logic [DATA_WIDTH-1:0]            data_r_rdata_o,
  output logic                             data_r_opc_o,
  output logic [NB_TARGETS-1:0]            tgt_req_o,
  output logic [ADDR_WIDTH-1:0]            tgt_add_o,
  output logic                             tgt_wen_o,
  output logic [DATA_WIDTH-1:0]            tgt_wdata_o,
  output logic [BE_WIDTH-1:0]              tgt_be_o,
  input  logic [NB_TARGETS-1:0]            tgt_gnt_i,
  input  logic [NB_TARGETS-1:0]            tgt_r_valid_i,
  input  logic [NB_TARGETS*DATA_WIDTH-1:0] tgt_r_rdata_i,
  input  logic [NB_TARGETS-1:0]            tgt_r_opc_i,
  output logic                             stray_resp_o
);

  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  // A FIFO entry is {unmapped flag, target select}; the select is ignored when the flag is set.
  logic [SEL_WIDTH:0]   fifo [MAX_OUTSTANDING];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [CNT_W-1:0]     count;

  logic                 hit;
  logic [SEL_WIDTH-1:0] sel;
  logic                 mapped;
  logic                 full;
  logic                 empty;
  logic                 push;
  logic                 pop;
  logic [SEL_WIDTH:0]   head;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : ptr + PTR_W'(1);
  endfunction

  assign hit    = (data_add_i & REGION_MASK) == REGION_VALUE;
  assign sel    = data_add_i[SEL_LSB +: SEL_WIDTH];
  assign mapped = hit && (32'(sel) < NB_TARGETS);
  assign full   = (count == CNT_W'(MAX_OUTSTANDING));
  assign empty  = (count == '0);
  assign head   = fifo[rd_ptr];

  assign tgt_add_o   = data_add_i;
  assign tgt_wen_o   = data_wen_i;
  assign tgt_wdata_o = data_wdata_i;
  assign tgt_be_o    = data_be_i;

  assign push = data_req_i && data_gnt_o;
  assign pop  = data_r_valid_o;

  // Request path: forward to the selected target, or self-grant unmapped accesses; block everything when full.
  always_comb begin
    tgt_req_o  = '0;
    data_gnt_o = 1'b0;
    if (!full) begin
      if (mapped) begin
        for (int k = 0; k < NB_TARGETS; k++) begin
          if (sel == SEL_WIDTH'(k)) begin
            tgt_req_o[k] = data_req_i;
            data_gnt_o   = tgt_gnt_i[k];
          end
        end
      end else begin
        data_gnt_o = data_req_i;
      end
    end
  end

  // Response path: select the FIFO head target, synthesise the error response, flag responses from anyone else.
  always_comb begin
    data_r_valid_o = 1'b0;
    data_r_rdata_o = '0;
    data_r_opc_o   = 1'b0;
    stray_resp_o   = 1'b0;
    for (int k = 0; k < NB_TARGETS; k++) begin
      if (!empty && !head[SEL_WIDTH] && head[SEL_WIDTH-1:0] == SEL_WIDTH'(k)) begin
        data_r_valid_o = tgt_r_valid_i[k];
        data_r_rdata_o = tgt_r_rdata_i[k*DATA_WIDTH +: DATA_WIDTH];
        data_r_opc_o   = tgt_r_opc_i[k];
      end else if (tgt_r_valid_i[k]) begin
        stray_resp_o = 1'b1;
      end
    end
    if (!empty && head[SEL_WIDTH]) begin
      data_r_valid_o = 1'b1;
      data_r_opc_o   = 1'b1;
    end
  end

  // Destination storage is written on every accepted request; contents need no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo[wr_ptr] <= {!mapped, sel};
    end
  end

  // Pointer and occupancy bookkeeping; a simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= next_ptr(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

`ifndef SYNTHESIS
  // Sanity checks on configuration and FIFO usage.
  always_ff @(posedge clk) begin
    if (!rst_i) begin
      assert (NB_TARGETS <= 2 ** SEL_WIDTH);
      assert (!(push && full));
      assert (!(pop && empty));
    end
  end
`endif

endmodule

// File: tb/tb_periph_demux_multi.sv
// tb_periph_demux_multi: directed stimulus with a response scoreboard for periph_demux_multi.
module tb_periph_demux_multi;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = 4;
  localparam int NT = 4;

  logic           clk = 1'b0;
  logic           rst_i;
  logic           data_req_i;
  logic [AW-1:0]  data_add_i;
  logic           data_wen_i;
  logic [DW-1:0]  data_wdata_i;
  logic [BW-1:0]  data_be_i;
  logic           data_gnt_o;
  logic           data_r_valid_o;
  logic [DW-1:0]  data_r_rdata_o;
  logic           data_r_opc_o;
  logic [NT-1:0]  tgt_req_o;
  logic [AW-1:0]  tgt_add_o;
  logic           tgt_wen_o;
  logic [DW-1:0]  tgt_wdata_o;
  logic [BW-1:0]  tgt_be_o;
  logic [NT-1:0]  tgt_gnt_i;
  logic [NT-1:0]  tgt_r_valid_i;
  logic [NT*DW-1:0] tgt_r_rdata_i;
  logic [NT-1:0]  tgt_r_opc_i;
  logic           stray_resp_o;

  typedef struct packed {
    logic [DW-1:0] rdata;
    logic          opc;
  } resp_t;

  resp_t sb[$];
  int checks = 0;
  int errors = 0;

  periph_demux_multi dut (
    .clk(clk), .rst_i(rst_i),
    .data_req_i(data_req_i), .data_add_i(data_add_i), .data_wen_i(data_wen_i),
    .data_wdata_i(data_wdata_i), .data_be_i(data_be_i), .data_gnt_o(data_gnt_o),
    .data_r_valid_o(data_r_valid_o), .data_r_rdata_o(data_r_rdata_o), .data_r_opc_o(data_r_opc_o),
    .tgt_req_o(tgt_req_o), .tgt_add_o(tgt_add_o), .tgt_wen_o(tgt_wen_o),
    .tgt_wdata_o(tgt_wdata_o), .tgt_be_o(tgt_be_o), .tgt_gnt_i(tgt_gnt_i),
    .tgt_r_valid_i(tgt_r_valid_i), .tgt_r_rdata_i(tgt_r_rdata_i), .tgt_r_opc_i(tgt_r_opc_i),
    .stray_resp_o(stray_resp_o)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic req, input logic [AW-1:0] addr, input logic wen,
                               input logic [DW-1:0] wdata, input logic [NT-1:0] gnt);
    data_req_i   = req;
    data_add_i   = addr;
    data_wen_i   = wen;
    data_wdata_i = wdata;
    tgt_gnt_i    = gnt;
  endtask

  task automatic expectResp(input logic [DW-1:0] rdata, input logic opc);
    resp_t r;
    r.rdata = rdata;
    r.opc   = opc;
    sb.push_back(r);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // Monitor: every response the DUT presents is matched against the oldest expected one.
  always @(negedge clk) begin
    if (data_r_valid_o) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_resp: got rdata 0x%0h opc %0b with nothing expected",
                 data_r_rdata_o, data_r_opc_o);
      end else begin
        resp_t exp_r;
        exp_r = sb.pop_front();
        checkOutput("resp_rdata", 64'(data_r_rdata_o), 64'(exp_r.rdata));
        checkOutput("resp_opc", 64'(data_r_opc_o), 64'(exp_r.opc));
      end
    end
  end

  // Directed stimulus sequence.
  initial begin
    rst_i         = 1'b1;
    data_be_i     = 4'hF;
    tgt_r_valid_i = '0;
    tgt_r_rdata_i = '0;
    tgt_r_opc_i   = '0;
    applyStimulus(1'b0, '0, 1'b1, '0, '0);
    tick();
    tick();
    sample();
    checkOutput("reset_gnt", 64'(data_gnt_o), 64'd0);
    checkOutput("reset_rvalid", 64'(data_r_valid_o), 64'd0);
    checkOutput("reset_tgt_req", 64'(tgt_req_o), 64'd0);
    checkOutput("reset_stray", 64'(stray_resp_o), 64'd0);
    checkOutput("reset_rdata", 64'(data_r_rdata_o), 64'd0);
    tick();
    rst_i = 1'b0;

    // Read to target 0 with an immediate grant, response the next cycle.
    applyStimulus(1'b1, 32'h1020_4000, 1'b1, '0, 4'b0001);
    sample();
    checkOutput("t1_gnt", 64'(data_gnt_o), 64'd1);
    checkOutput("t1_tgt_req", 64'(tgt_req_o), 64'b0001);
    checkOutput("t1_tgt_add", 64'(tgt_add_o), 64'h1020_4000);
    expectResp(32'h0000_CAFE, 1'b0);
    tick();
    applyStimulus(1'b0, '0, 1'b1, '0, '0);
    tgt_r_valid_i = 4'b0001;
    tgt_r_rdata_i[0*DW +: DW] = 32'h0000_CAFE;
    sample();
    checkOutput("t1_stray", 64'(stray_resp_o), 64'd0);
    tick();
    tgt_r_valid_i = '0;

    // Write to target 3: grant withheld one cycle, then an error response forwarded.
    data_be_i = 4'hA;
    applyStimulus(1'b1, 32'h1020_4C00, 1'b0, 32'hDEAD_BEEF, 4'b0000);
    sample();
    checkOutput("t2_tgt_req", 64'(tgt_req_o), 64'b1000);
    checkOutput("t2_gnt_wait", 64'(data_gnt_o), 64'd0);
    checkOutput("t2_wen", 64'(tgt_wen_o), 64'd0);
    checkOutput("t2_wdata", 64'(tgt_wdata_o), 64'hDEAD_BEEF);
    checkOutput("t2_be", 64'(tgt_be_o), 64'hA);
    tick();
    tgt_gnt_i = 4'b1000;
    sample();
    checkOutput("t2_gnt", 64'(data_gnt_o), 64'd1);
    expectResp(32'h0000_1234, 1'b1);
    tick();
    applyStimulus(1'b0, '0, 1'b1, '0, '0);
    tgt_r_valid_i = 4'b1000;
    tgt_r_opc_i   = 4'b1000;
    tgt_r_rdata_i[3*DW +: DW] = 32'h0000_1234;
    sample();
    tick();
    tgt_r_valid_i = '0;
    tgt_r_opc_i   = '0;

    // Unmapped select then region miss, back to back: self-granted, error responses.
    applyStimulus(1'b1, 32'h1020_5000, 1'b1, '0, 4'b1111);
    sample();
    checkOutput("t3a_gnt", 64'(data_gnt_o), 64'd1);
    checkOutput("t3a_tgt_req", 64'(tgt_req_o), 64'd0);
    expectResp(32'h0, 1'b1);
    tick();
    applyStimulus(1'b1, 32'h1030_0000, 1'b1, '0, 4'b1111);
    sample();
    checkOutput("t3b_gnt", 64'(data_gnt_o), 64'd1);
    checkOutput("t3b_tgt_req", 64'(tgt_req_o), 64'd0);
    expectResp(32'h0, 1'b1);
    tick();
    applyStimulus(1'b0, '0, 1'b1, '0, '0);
    sample();
    tick();

    // Fill the FIFO with target 1 and target 2, then a blocked third request.
    applyStimulus(1'b1, 32'h1020_4400, 1'b1, '0, 4'b0010);
    sample();
    checkOutput("t4_gnt1", 64'(data_gnt_o), 64'd1);
    checkOutput("t4_req1", 64'(tgt_req_o), 64'b0010);
    expectResp(32'h0000_1111, 1'b0);
    tick();
    applyStimulus(1'b1, 32'h1020_4800, 1'b1, '0, 4'b0100);
    sample();
    checkOutput("t4_gnt2", 64'(data_gnt_o), 64'd1);
    checkOutput("t4_req2", 64'(tgt_req_o), 64'b0100);
    expectResp(32'h0000_2222, 1'b0);
    tick();
    applyStimulus(1'b1, 32'h1020_4000, 1'b1, '0, 4'b0001);
    sample();
    checkOutput("t4_full_gnt", 64'(data_gnt_o), 64'd0);
    checkOutput("t4_full_req", 64'(tgt_req_o), 64'd0);
    tick();
    tgt_r_valid_i = 4'b0100;
    tgt_r_rdata_i[2*DW +: DW] = 32'h0000_2222;
    sample();
    checkOutput("t5_stray", 64'(stray_resp_o), 64'd1);
    checkOutput("t5_rvalid", 64'(data_r_valid_o), 64'd0);
    checkOutput("t5_full_gnt", 64'(data_gnt_o), 64'd0);
    tick();
    tgt_r_valid_i = 4'b0010;
    tgt_r_rdata_i[1*DW +: DW] = 32'h0000_1111;
    sample();
    checkOutput("t4_pop_full_gnt", 64'(data_gnt_o), 64'd0);
    checkOutput("t4_pop_stray", 64'(stray_resp_o), 64'd0);
    tick();
    tgt_r_valid_i = 4'b0100;
    sample();
    checkOutput("t4_third_gnt", 64'(data_gnt_o), 64'd1);
    checkOutput("t4_third_req", 64'(tgt_req_o), 64'b0001);
    expectResp(32'h0000_3333, 1'b0);
    tick();
    applyStimulus(1'b0, '0, 1'b1, '0, '0);
    tgt_r_valid_i = 4'b0001;
    tgt_r_rdata_i[0*DW +: DW] = 32'h0000_3333;
    sample();
    tick();
    tgt_r_valid_i = '0;

    // Reset with two transactions outstanding; a late response is only flagged.
    applyStimulus(1'b1, 32'h1020_4400, 1'b1, '0, 4'b0010);
    sample();
    checkOutput("t6_gnt1", 64'(data_gnt_o), 64'd1);
    tick();
    applyStimulus(1'b1, 32'h1020_4800, 1'b1, '0, 4'b0100);
    sample();
    checkOutput("t6_gnt2", 64'(data_gnt_o), 64'd1);
    tick();
    applyStimulus(1'b0, '0, 1'b1, '0, '0);
    rst_i = 1'b1;
    sample();
    tick();
    rst_i = 1'b0;
    sample();
    checkOutput("t6_rvalid", 64'(data_r_valid_o), 64'd0);
    checkOutput("t6_gnt", 64'(data_gnt_o), 64'd0);
    checkOutput("t6_tgt_req", 64'(tgt_req_o), 64'd0);
    checkOutput("t6_opc", 64'(data_r_opc_o), 64'd0);
    tick();
    tgt_r_valid_i = 4'b0010;
    sample();
    checkOutput("t6_late_stray", 64'(stray_resp_o), 64'd1);
    checkOutput("t6_late_rvalid", 64'(data_r_valid_o), 64'd0);
    tick();
    tgt_r_valid_i = '0;
    applyStimulus(1'b1, 32'h1030_0000, 1'b1, '0, '0);
    sample();
    checkOutput("t6_post_gnt", 64'(data_gnt_o), 64'd1);
    expectResp(32'h0, 1'b1);
    tick();
    applyStimulus(1'b0, '0, 1'b1, '0, '0);
    sample();
    tick();
    tick();

    checkOutput("sb_drained", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
